// File: rtl/tb_mem_pipe.sv
// tb_mem_pipe: dual-port (instruction + data) simulation memory with a
// programmable response latency, multiple outstanding requests per channel,
// error responses for misaligned/out-of-range accesses and a tohost mailbox.
// Optional feature macro: TB_MEM_RAND_STALL_EN (LFSR-driven random grant stalls).

// One request/response channel: outstanding counter plus a RESP_LAT-deep
// {valid, err, rdata} shift pipe. gnt already includes req.
module tb_mem_pipe_chan #(
  parameter int RESP_LAT        = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        stall_ok,
  input  logic        rsp_err,
  input  logic [31:0] rsp_rdata,
  output logic        gnt,
  output logic        valid,
  output logic        err,
  output logic [31:0] rdata
);
  logic [3:0]               cnt;
  logic [RESP_LAT:1]        vld_pipe;
  logic [RESP_LAT:1]        err_pipe;
  logic [RESP_LAT:1][31:0]  dat_pipe;

  assign gnt   = req && (cnt < 4'(MAX_OUTSTANDING)) && stall_ok;
  assign valid = vld_pipe[RESP_LAT];
  assign err   = err_pipe[RESP_LAT];
  assign rdata = dat_pipe[RESP_LAT];

  // Shift accepted responses toward the output; track accepted-but-unanswered count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= '0;
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= gnt;
      err_pipe[1] <= gnt && rsp_err;
      dat_pipe[1] <= gnt ? rsp_rdata : 32'h0;
      for (int k = 2; k <= RESP_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
      if (gnt && !valid)
        cnt <= cnt + 4'd1;
      else if (!gnt && valid)
        cnt <= cnt - 4'd1;
    end
  end
endmodule

module tb_mem_pipe #(
  parameter int          MEM_DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          RESP_LAT        = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] TOHOST_ADDR     = 32'h8000_0000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        test_done,
  output logic [31:0] test_code
);
  localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

  // Parameter legality, caught at elaboration
  if (RESP_LAT < 1 || RESP_LAT > 8) begin : g_bad_lat
    $error("RESP_LAT must be 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_max
    $error("MAX_OUTSTANDING must be 1..8");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  logic [31:0] mem [0:MEM_DEPTH_WORDS-1];

  // Word offsets from BASE_ADDR; anything below the base wraps to a huge value
  logic [31:2] i_widx, d_widx;
  logic        i_err, d_err, d_tohost;
  logic [31:0] i_rd, d_rd;
  logic        i_stall_ok, d_stall_ok;

  assign i_widx   = instr_addr[31:2] - BASE_ADDR[31:2];
  assign d_widx   = data_addr[31:2]  - BASE_ADDR[31:2];
  assign d_tohost = (data_addr == TOHOST_ADDR);
  assign i_err    = (instr_addr[1:0] != 2'b00) ||
                    ({2'b00, i_widx} >= 32'(MEM_DEPTH_WORDS));
  assign d_err    = !d_tohost && ((data_addr[1:0] != 2'b00) ||
                    ({2'b00, d_widx} >= 32'(MEM_DEPTH_WORDS)));

  // Read data captured at acceptance; stores and errors return zero
  always_comb begin
    i_rd = 32'h0;
    d_rd = 32'h0;
    if (!i_err)
      i_rd = mem[i_widx[IDX_W+1:2]];
    if (d_tohost)
      d_rd = data_wr ? 32'h0 : {31'b0, test_done};
    else if (!d_err && !data_wr)
      d_rd = mem[d_widx[IDX_W+1:2]];
  end

`ifdef TB_MEM_RAND_STALL_EN
  logic [15:0] i_lfsr, d_lfsr;

  // Fibonacci LFSRs (taps 16,14,13,11) advanced every cycle to throttle grants
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_lfsr <= LFSR_SEED;
      d_lfsr <= LFSR_SEED;
    end else begin
      i_lfsr <= {i_lfsr[14:0], i_lfsr[15] ^ i_lfsr[13] ^ i_lfsr[12] ^ i_lfsr[10]};
      d_lfsr <= {d_lfsr[14:0], d_lfsr[15] ^ d_lfsr[13] ^ d_lfsr[12] ^ d_lfsr[10]};
    end
  end

  assign i_stall_ok = i_lfsr[0];
  assign d_stall_ok = d_lfsr[1];
`else
  assign i_stall_ok = 1'b1;
  assign d_stall_ok = 1'b1;
`endif

  tb_mem_pipe_chan #(.RESP_LAT(RESP_LAT), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_instr (
    .clk(clk), .reset_n(reset_n), .req(instr_req), .stall_ok(i_stall_ok),
    .rsp_err(i_err), .rsp_rdata(i_rd),
    .gnt(instr_gnt), .valid(instr_valid), .err(instr_err), .rdata(instr_rdata)
  );

  tb_mem_pipe_chan #(.RESP_LAT(RESP_LAT), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data (
    .clk(clk), .reset_n(reset_n), .req(data_req), .stall_ok(d_stall_ok),
    .rsp_err(d_err), .rsp_rdata(d_rd),
    .gnt(data_gnt), .valid(data_valid), .err(data_err), .rdata(data_rdata)
  );

  // Byte-merge accepted stores; contents survive reset, the fetch path reads old data
  always_ff @(posedge clk) begin
    if (reset_n && data_gnt && data_wr && !d_err && !d_tohost) begin
      for (int b = 0; b < 4; b++)
        if (data_byteen[b])
          mem[d_widx[IDX_W+1:2]][8*b +: 8] <= data_wdata[8*b +: 8];
    end
  end

  // Tohost mailbox: first store latches the code, test_done stays set
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      test_done <= 1'b0;
      test_code <= 32'h0;
    end else if (data_gnt && data_wr && d_tohost) begin
      test_done <= 1'b1;
      if (!test_done)
        test_code <= data_wdata;
    end
  end
endmodule
